// File: rtl/sdb_operand_if.sv
// Operand handshake bundle between an upstream producer, the operand stage and the adder core.
interface sdb_operand_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             in_sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_p;
  logic             out_c;
  logic             out_sub;

  // Environment side: offers operand pairs and consumes prepared operands
  modport master (
    output in_valid, in_a, in_b, in_c, in_sub, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_p, out_c, out_sub
  );

  // Stage side
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_sub, out_ready,
    output in_ready, out_valid, out_a, out_b, out_p, out_c, out_sub
  );
endinterface

// File: rtl/sdb_operand_stage.sv
// Operand preparation for the sdb_inner adder: optional b inversion for subtract, propagate
// vector precompute, and a 2-entry skid buffer so the adder sees stable inputs under stall.
module sdb_operand_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  sdb_operand_if.slave bus
);

  if ((WIDTH % 2) != 0 || WIDTH <= 2) begin : g_width_check
    $error("sdb_operand_stage: WIDTH must be even and greater than 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             c;
    logic             sub;
  } entry_t;

  // Bit 0 is the MAIN valid flag, bit 1 the SKID valid flag
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  entry_t main_q;
  entry_t skid_q;
  entry_t prep_c;
  logic   in_fire;
  logic   out_fire;
  logic   load_main_in;
  logic   load_main_skid;
  logic   load_skid;

  // Prepare the incoming pair before capture
  always_comb begin
    prep_c     = '0;
    prep_c.a   = bus.in_a;
    prep_c.b   = bus.in_sub ? ~bus.in_b : bus.in_b;
    prep_c.p   = bus.in_a ^ prep_c.b;
    prep_c.c   = bus.in_sub | bus.in_c;
    prep_c.sub = bus.in_sub;
  end

  assign in_fire  = bus.in_valid & ~state[1];
  assign out_fire = state[0] & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (out_fire && in_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Entry storage; MAIN only changes on a load so it stays bit-stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= prep_c;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= prep_c;
    end
  end

  assign bus.in_ready  = ~state[1];
  assign bus.out_valid = state[0];
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_p     = main_q.p;
  assign bus.out_c     = main_q.c;
  assign bus.out_sub   = main_q.sub;

endmodule

// File: tb/tb_sdb_operand_stage.sv
// Self-checking bench for sdb_operand_stage: vector table, hand-written corner sequences and a
// scoreboard monitor that follows every transfer.
module tb_sdb_operand_stage;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdb_operand_if #(.WIDTH(W)) bus ();

  sdb_operand_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         c;
    logic         sub;
    logic [W-1:0] sum;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W-1:0] eb;
    logic [W-1:0] ep;
    logic         ec;
    logic [W-1:0] esum;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  exp_t sb[$];
  logic        stall_pending = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sub);
    exp_t e;
    e.a   = a;
    e.b   = sub ? ~b : b;
    e.p   = a ^ e.b;
    e.c   = sub ? 1'b1 : c;
    e.sub = sub;
    e.sum = sub ? W'(a - b) : W'(a + b + {7'b0, c});
    return e;
  endfunction

  function automatic logic [31:0] out_word();
    return 32'({bus.out_a, bus.out_b, bus.out_p, bus.out_c, bus.out_sub});
  endfunction

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_pending = 1'b0;
    end else begin
      check("occupancy", 32'(sb.size()), 32'(bus.out_valid) + 32'(!bus.in_ready));
      if (stall_pending) check("stall_hold", out_word(), held);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(bus.out_a), 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_a", 32'(bus.out_a), 32'(e.a));
          check("sb_b", 32'(bus.out_b), 32'(e.b));
          check("sb_p", 32'(bus.out_p), 32'(e.p));
          check("sb_c", 32'(bus.out_c), 32'(e.c));
          check("sb_sub", 32'(bus.out_sub), 32'(e.sub));
          check("sb_sum", 32'(W'(bus.out_a + bus.out_b + {7'b0, bus.out_c})), 32'(e.sum));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_c, bus.in_sub));
      stall_pending = bus.out_valid && !bus.out_ready;
      held = out_word();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sub);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_sub   = sub;
  endtask

  vec_t vecs[8];

  initial begin
    int   start;
    logic fired;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h0F, 8'h33, 1'b0, 8'h4B};
    vecs[1] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'hFE, 8'hEE, 1'b1, 8'h0F};
    vecs[2] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'hAA, 8'hFF, 1'b1, 8'h00};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFE};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b1, 8'h4B};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b1, 8'h80, 8'h00, 1'b1, 8'h01};
    vecs[7] = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h01, 8'h7E, 1'b1, 8'h81};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = 1'b0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outputs", out_word(), 32'd0);

    // Vector table: one transfer each, latency 1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub);
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_a", i), 32'(bus.out_a), 32'(vecs[i].a));
      check($sformatf("vec%0d_b", i), 32'(bus.out_b), 32'(vecs[i].eb));
      check($sformatf("vec%0d_p", i), 32'(bus.out_p), 32'(vecs[i].ep));
      check($sformatf("vec%0d_c", i), 32'(bus.out_c), 32'(vecs[i].ec));
      check($sformatf("vec%0d_sub", i), 32'(bus.out_sub), 32'(vecs[i].sub));
      check($sformatf("vec%0d_sum", i),
            32'(W'(bus.out_a + bus.out_b + {7'b0, bus.out_c})), 32'(vecs[i].esum));
      tick();
      check($sformatf("vec%0d_drain", i), 32'(bus.out_valid), 32'd0);
    end

    // Back-pressure: A, B buffered, C held upstream, then drained in order
    bus.out_ready = 1'b0;
    offer(8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    check("bp_a_ready", 32'(bus.in_ready), 32'd1);
    offer(8'h03, 8'h04, 1'b0, 1'b0);
    tick();
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    offer(8'h05, 8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      check("bp_stall_a", 32'(bus.out_a), 32'h01);
      check("bp_stall_b", 32'(bus.out_b), 32'h02);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_out_b_a", 32'(bus.out_a), 32'h03);
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_out_c_a", 32'(bus.out_a), 32'h05);
    check("bp_out_c_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming: one pair per cycle
    start = n_out;
    for (int i = 0; i < 16; i++) begin
      offer(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
      tick();
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_count", 32'(n_out - start), 32'd16);
    check("stream_empty", 32'(bus.out_valid), 32'd0);

    // Reset with both entries full and a pair offered during reset
    bus.out_ready = 1'b0;
    offer(8'h11, 8'h22, 1'b1, 1'b0);
    tick();
    offer(8'h33, 8'h44, 1'b0, 1'b1);
    tick();
    check("mid_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    offer(8'hEE, 8'hEE, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_data", out_word(), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("mid_rst_no_ghost", 32'(bus.out_valid), 32'd0);

    // Random valid/ready toggling; offered data held until accepted
    fired = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.in_valid || fired)
        offer(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("rand_drained_valid", 32'(bus.out_valid), 32'd0);
    check("rand_drained_sb", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdb_operand_stage.md
Name: sdb_operand_stage

Overview:
Registered operand-preparation stage that sits directly upstream of the sdb_inner adder core.
- Accepts operand pairs over a valid/ready handshake.
- Applies optional subtraction (invert b, force carry-in).
- Computes the per-bit propagate vector p = a ^ b_eff.
- Holds the prepared operands in a 2-entry skid buffer, so the combinational adder sees stable a/b/p/c_in at full throughput under back-pressure.

Parameters:
- WIDTH, 8, operand width. Must be even and greater than 2 (same constraint as the adder core).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operand pair valid
- in_ready  output  1  stage can accept an operand pair
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_c  input  1  carry-in for addition (ignored when in_sub=1)
- in_sub  input  1  1 = compute a - b
- out_valid  output  1  prepared operands valid
- out_ready  input  1  downstream (adder/result stage) accepts
- out_a  output  WIDTH  a, registered
- out_b  output  WIDTH  b_eff = in_sub ? ~in_b : in_b, registered
- out_p  output  WIDTH  out_a ^ out_b
- out_c  output  1  c_eff = in_sub ? 1 : in_c, registered
- out_sub  output  1  registered in_sub, for downstream overflow/borrow interpretation

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: two entries, MAIN (drives the out_* ports) and SKID. Each entry holds {a, b_eff, p, c_eff, sub} plus a valid bit.
- Preparation happens before capture: b_eff, c_eff and p are computed combinationally from in_* and stored. out_p is always the stored value, never recomputed from outputs.
- in_ready = !skid_valid (direct decode of a flop, no combinational path from out_ready).
- out_valid = main_valid.
- Reset (rst=1 at a clock edge):
  - main_valid=0, skid_valid=0; all data registers cleared to 0.
  - Resulting outputs: out_valid=0, out_a/out_b/out_p=0, out_c=0, out_sub=0, in_ready=1.
  - Any in_fire or out_fire in a reset cycle is discarded.
- Update rules per edge (rst=0):
  - MAIN empty, in_fire: load MAIN. out_valid=1 next cycle (latency 1).
  - MAIN full, out_fire, SKID empty, in_fire: load MAIN with the new pair (streaming, 1 per cycle).
  - MAIN full, out_fire, SKID empty, no in_fire: main_valid=0.
  - MAIN full, !out_ready, in_fire: load SKID. skid_valid=1, so in_ready=0 next cycle.
  - MAIN full, out_fire, SKID full: move SKID to MAIN; skid_valid=0, in_ready=1 next cycle. in_fire is impossible in this state.
  - MAIN full, !out_ready: MAIN contents are held bit-stable (the adder output must not glitch while stalled).
- Ordering: strict FIFO. SKID is never output ahead of MAIN.
- Arithmetic rules:
  - All vectors are WIDTH bits. No sign extension or width growth in this stage.
  - Subtraction is two's complement via ~b plus carry 1. For a=b with sub=1: p = all ones, c=1.
- Data-path invariant: data fields are don't-care in intent while valid=0, but are never X (cleared at reset).
- Reset mid-operation: buffered entries are dropped with no output pulse. First accept is possible in the cycle after rst deasserts.
- Occupancy: never exceeds 2.

Test Plan:
- Add path, WIDTH=8. in_a=0x3C, in_b=0x0F, in_c=0, in_sub=0, out_ready=1 -> next cycle out_valid=1, out_a=0x3C, out_b=0x0F, out_p=0x33, out_c=0, out_sub=0.
- Subtract path. in_a=0x10, in_b=0x01, in_sub=1, in_c=0 -> out_b=0xFE, out_p=0xEE, out_c=1, out_sub=1. Downstream sum = 0x0F.
- Back-pressure with out_ready=0:
  - Send A=(0x01,0x02), then B=(0x03,0x04) -> in_ready=0 the cycle after B is accepted; C is held upstream.
  - Raise out_ready -> A, B, C emerge in order on consecutive cycles with no loss or duplication.
  - out_* stays bit-stable throughout the stall.
- Streaming: 16 random pairs with in_valid=1 and out_ready=1 every cycle -> one output per cycle, latency 1. Every out_p equals out_a ^ out_b and matches a software model of a + b_eff + c_eff once passed through sdb_inner.
- Reset mid-operation: fill both entries, assert rst for 1 cycle alongside in_valid=1 -> out_valid=0 and all data outputs 0 after the reset edge, in_ready=1. The pair offered during reset never appears at the output.
- Random ready/valid toggling over 2000 cycles with a scoreboard -> order preserved, occupancy ≤ 2, and no out_fire while out_valid=0.
